// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock, truncating toward zero.
// Divide-by-zero finishes one cycle after the start; every other operation takes WIDTH+1 cycles.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic s, input logic [WIDTH-1:0] v);
    if (s) begin
      neg_if = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      neg_if = v;
    end
  endfunction

  // Next-state, datapath step and output register inputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;
    busy_d      = busy_q;

    // The dividend magnitude lives in quo_q and shifts out into the remainder MSB-first
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};

    if (ctrl_DIV) begin
      state_d  = RUN;
      busy_d   = 1'b1;
      cnt_d    = {CW{1'b0}};
      rem_d    = {WIDTH{1'b0}};
      sign_a_d = data_operandA[WIDTH-1];
      sign_b_d = data_operandB[WIDTH-1];
      quo_d    = neg_if(data_operandA[WIDTH-1], data_operandA);
      dvs_d    = neg_if(data_operandB[WIDTH-1], data_operandB);
      zero_d   = (data_operandB == {WIDTH{1'b0}});
      ovf_d    = (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
        end
        RUN: begin
          if (zero_q) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            rdy_d       = 1'b1;
            result_d    = {WIDTH{1'b0}};
            remainder_d = neg_if(sign_a_q, quo_q);
            exc_d       = 1'b1;
          end else if (cnt_q == CW'(WIDTH)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            rdy_d       = 1'b1;
            result_d    = neg_if(sign_a_q ^ sign_b_q, quo_q);
            remainder_d = neg_if(sign_a_q, rem_q);
            exc_d       = ovf_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
            quo_d = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
            if (diff_s[WIDTH]) begin
              rem_d = shifted_s[WIDTH-1:0];
            end else begin
              rem_d = diff_s[WIDTH-1:0];
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): latency, sign handling, exceptions, abort and reset.
module tb_seq_divider;

  logic        clock;
  logic        resetn;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion; en is the edge count from E0 to DONE entry.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee, input int en);
    int n;
    int busy_cnt;
    bit got;
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check({nm, "_busy_e0"}, {31'd0, busy}, 32'd1);
    busy_cnt = 1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({nm, "_latency"}, n, en);
    check({nm, "_busy_cycles"}, busy_cnt, en);
    check({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({nm, "_result"}, data_result, eq);
    check({nm, "_remainder"}, data_remainder, er);
    check({nm, "_exception"}, {31'd0, data_exception}, {31'd0, ee});
    @(posedge clock);
    #1;
    check({nm, "_rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
    check({nm, "_result_hold"}, data_result, eq);
  endtask

  initial begin
    int pulses;
    resetn        = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    run_op("p100_p7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    run_op("m100_p7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33);
    run_op("p100_m7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33);
    run_op("m100_m7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33);
    run_op("div_zero",  32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 1);
    run_op("neg_zero",  32'hFFFFFFFD,   32'd0,          32'd0,          32'hFFFFFFFD,   1'b1, 1);
    run_op("overflow",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1, 33);
    run_op("min_by_1",  32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33);
    run_op("small_big", 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33);
    run_op("max_by_min",32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0, 33);

    // Abort: 1000/3 restarted with 9/2 at E10
    pulses = 0;
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd2;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    begin
      int n;
      int first;
      first = -1;
      for (n = 1; n <= 40; n++) begin
        @(posedge clock);
        #1;
        if (data_resultRDY) begin
          pulses++;
          if (first < 0) begin
            first = n;
            check("abort_result", data_result, 32'd4);
            check("abort_remainder", data_remainder, 32'd1);
          end
        end
      end
      check("abort_latency", first, 33);
    end
    check("abort_pulses", pulses, 1);

    // Reset asserted at E15 of 1000/3
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_result", data_result, 32'd0);
    check("rst_mid_remainder", data_remainder, 32'd0);
    check("rst_mid_exception", {31'd0, data_exception}, 32'd0);
    check("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) pulses++;
    end
    check("rst_no_pulse", pulses, 0);
    run_op("after_rst", 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
